// File: rtl/ubuf_port_arbiter.sv
// Shares the unified buffer's single host-side port between host req/ack accesses
// and engine writeback words queued in a small elastic FIFO.
module ubuf_port_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 64,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_WAIT   = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          host_req,
  input  logic                          host_we,
  input  logic [ADDR_W-1:0]             host_addr,
  input  logic [DATA_W-1:0]             host_wdata,
  output logic                          host_ack,
  output logic [DATA_W-1:0]             host_rdata,
  input  logic                          eng_valid,
  output logic                          eng_ready,
  input  logic [ADDR_W-1:0]             eng_addr,
  input  logic [DATA_W-1:0]             eng_wdata,
  output logic                          ub_en,
  output logic                          ub_we,
  output logic [ADDR_W-1:0]             ub_addr,
  output logic [DATA_W-1:0]             ub_wdata,
  input  logic [DATA_W-1:0]             ub_rdata,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          eng_idle,
  output logic [1:0]                    dbg_host_state
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(MAX_WAIT + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;

  // Handshakes: engine word transfers when eng_valid && eng_ready at a rising edge;
  // host holds host_req (with we/addr/wdata stable) until the one-cycle host_ack.

  logic [1:0]        state;
  logic              host_we_q;
  logic [SW-1:0]     starve_cnt;
  logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              ub_eng;

  logic fifo_full, fifo_empty;
  logic host_elig, eng_elig, host_win, eng_win;
  logic push, pop;

  always_comb begin
    fifo_full  = (count == CW'(FIFO_DEPTH));
    fifo_empty = (count == '0);
    host_elig  = (state == ST_IDLE) && host_req;
    eng_elig   = !fifo_empty;
    // The engine has priority until the host has lost MAX_WAIT decisions in a row.
    host_win   = host_elig && (!eng_elig || (starve_cnt == SW'(MAX_WAIT)));
    eng_win    = eng_elig && !host_win;
    push       = eng_valid && !fifo_full;
    pop        = eng_win;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= eng_addr;
      fifo_data[wr_ptr] <= eng_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      host_we_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (host_win) begin
            state     <= ST_ISSUE;
            host_we_q <= host_we;
          end
        end
        ST_ISSUE: state <= ST_RESP;
        ST_RESP:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (!host_req || host_win) begin
      starve_cnt <= '0;
    end else if (host_elig && starve_cnt != SW'(MAX_WAIT)) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end

  // Idle decisions hold we/addr/wdata so the ubuf bus only toggles on real accesses.
  always_ff @(posedge clk) begin
    if (rst) begin
      ub_en    <= 1'b0;
      ub_we    <= 1'b0;
      ub_addr  <= '0;
      ub_wdata <= '0;
      ub_eng   <= 1'b0;
    end else if (host_win) begin
      ub_en    <= 1'b1;
      ub_we    <= host_we;
      ub_addr  <= host_addr;
      ub_wdata <= host_wdata;
      ub_eng   <= 1'b0;
    end else if (eng_win) begin
      ub_en    <= 1'b1;
      ub_we    <= 1'b1;
      ub_addr  <= fifo_addr[rd_ptr];
      ub_wdata <= fifo_data[rd_ptr];
      ub_eng   <= 1'b1;
    end else begin
      ub_en    <= 1'b0;
      ub_eng   <= 1'b0;
    end
  end

  always_comb begin
    host_ack       = (state == ST_RESP);
    host_rdata     = (state == ST_RESP && !host_we_q) ? ub_rdata : '0;
    eng_ready      = !fifo_full;
    fifo_count     = count;
    eng_idle       = fifo_empty && !(ub_en && ub_eng);
    dbg_host_state = state;
  end

endmodule

// File: tb/tb_ubuf_port_arbiter.sv
// Directed bench for ubuf_port_arbiter: host access, engine drain ordering,
// starvation override, simultaneous eligibility and mid-operation reset.
module tb_ubuf_port_arbiter;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 64;
  localparam int LW     = 1 + ADDR_W + DATA_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              host_req, host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_ack;
  logic [DATA_W-1:0] host_rdata;
  logic              eng_valid, eng_ready;
  logic [ADDR_W-1:0] eng_addr;
  logic [DATA_W-1:0] eng_wdata;
  logic              ub_en, ub_we;
  logic [ADDR_W-1:0] ub_addr;
  logic [DATA_W-1:0] ub_wdata;
  logic [DATA_W-1:0] ub_rdata = '0;
  logic [2:0]        fifo_count;
  logic              eng_idle;
  logic [1:0]        dbg_host_state;

  int n_cmp = 0;
  int n_err = 0;
  logic [LW-1:0] log_q[$];
  logic [LW-1:0] exp_q[$];

  always #5 clk = ~clk;

  ubuf_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(4), .MAX_WAIT(3)) dut (
    .clk(clk), .rst(rst),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_rdata(host_rdata),
    .eng_valid(eng_valid), .eng_ready(eng_ready), .eng_addr(eng_addr), .eng_wdata(eng_wdata),
    .ub_en(ub_en), .ub_we(ub_we), .ub_addr(ub_addr), .ub_wdata(ub_wdata), .ub_rdata(ub_rdata),
    .fifo_count(fifo_count), .eng_idle(eng_idle), .dbg_host_state(dbg_host_state)
  );

  function automatic logic [DATA_W-1:0] ub_model(input logic [ADDR_W-1:0] a);
    if (a == 16'h0010) return 64'hDEAD_BEEF_0000_0001;
    return {16'h5A5A, 32'h0, a};
  endfunction

  function automatic logic [LW-1:0] ent(input logic we, input logic [ADDR_W-1:0] a,
                                        input logic [DATA_W-1:0] d);
    return {we, a, d};
  endfunction

  // Unified buffer stand-in: read data one cycle after the access, plus an access log.
  always @(posedge clk) begin
    if (ub_en && !ub_we) ub_rdata <= ub_model(ub_addr);
    if (ub_en) log_q.push_back({ub_we, ub_addr, ub_wdata});
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_log(input string tag);
    int n;
    check({tag, "_len"}, 128'(log_q.size()), 128'(exp_q.size()));
    n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check($sformatf("%s_%0d", tag, i), 128'(log_q[i]), 128'(exp_q[i]));
    log_q.delete();
    exp_q.delete();
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int b = 0;
    while (!eng_idle && b < budget) begin
      @(negedge clk);
      b++;
    end
    check(tag, 128'(eng_idle), 128'(1));
  endtask

  initial begin
    rst = 1'b1; host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    eng_valid = 1'b0; eng_addr = '0; eng_wdata = '0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_ub_en", 128'(ub_en), 128'(0));
    check("rst_host_ack", 128'(host_ack), 128'(0));
    check("rst_eng_ready", 128'(eng_ready), 128'(1));
    check("rst_fifo_count", 128'(fifo_count), 128'(0));
    check("rst_eng_idle", 128'(eng_idle), 128'(1));
    check("rst_host_rdata", 128'(host_rdata), 128'(0));
    rst = 1'b0;

    // Host read without contention: ub at N+1, ack at N+2
    host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0010; host_wdata = '0;
    @(negedge clk);
    check("rd_ub_en", 128'(ub_en), 128'(1));
    check("rd_ub_we", 128'(ub_we), 128'(0));
    check("rd_ub_addr", 128'(ub_addr), 128'(16'h0010));
    check("rd_ack_early", 128'(host_ack), 128'(0));
    @(negedge clk);
    check("rd_ack", 128'(host_ack), 128'(1));
    check("rd_rdata", 128'(host_rdata), 128'(64'hDEAD_BEEF_0000_0001));
    host_req = 1'b0;
    @(negedge clk);
    check("rd_ack_pulse", 128'(host_ack), 128'(0));
    check("rd_rdata_zero", 128'(host_rdata), 128'(0));

    // Engine burst of 6 words; idle host lets the FIFO drain one per cycle
    log_q.delete();
    begin
      int acc = 0;
      int guard = 0;
      logic rdy;
      while (acc < 6 && guard < 50) begin
        eng_valid = 1'b1;
        eng_addr  = 16'h0100 + 16'(acc);
        eng_wdata = 64'h1111_0000_0000_0000 + 64'(acc);
        rdy = eng_ready;
        @(negedge clk);
        if (rdy) acc++;
        guard++;
      end
      check("burst_accepted", 128'(acc), 128'(6));
    end
    eng_valid = 1'b0;
    wait_idle("burst_idle", 20);
    check("burst_count", 128'(fifo_count), 128'(0));
    for (int i = 0; i < 6; i++)
      exp_q.push_back(ent(1'b1, 16'h0100 + 16'(i), 64'h1111_0000_0000_0000 + 64'(i)));
    compare_log("burst_order");

    // Starvation: FIFO kept busy, host write loses 3 decisions, wins the 4th
    for (int k = 0; k < 14; k++) begin
      check($sformatf("starve_ack_t%0d", k), 128'(host_ack), 128'(k == 7));
      if (k == 6) check("starve_ub_addr", 128'(ub_addr), 128'(16'h0020));
      if (k == 7) check("starve_wr_rdata", 128'(host_rdata), 128'(0));
      eng_valid  = (k <= 9);
      eng_addr   = 16'h0200 + 16'(k);
      eng_wdata  = 64'h2222_0000_0000_0000 + 64'(k);
      host_req   = (k >= 2 && k < 7);
      host_we    = 1'b1;
      host_addr  = 16'h0020;
      host_wdata = 64'hCAFE_F00D_0000_0020;
      @(negedge clk);
    end
    eng_valid = 1'b0;
    wait_idle("starve_idle", 20);
    for (int i = 0; i < 4; i++)
      exp_q.push_back(ent(1'b1, 16'h0200 + 16'(i), 64'h2222_0000_0000_0000 + 64'(i)));
    exp_q.push_back(ent(1'b1, 16'h0020, 64'hCAFE_F00D_0000_0020));
    for (int i = 4; i < 10; i++)
      exp_q.push_back(ent(1'b1, 16'h0200 + 16'(i), 64'h2222_0000_0000_0000 + 64'(i)));
    compare_log("starve_order");

    // Simultaneous eligibility with starve_cnt=0: engine first, then host
    host_req = 1'b0;
    eng_valid = 1'b1; eng_addr = 16'h0300; eng_wdata = 64'h3333_0000_0000_0000;
    @(negedge clk);
    eng_valid = 1'b0;
    host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0030; host_wdata = '0;
    check("sim_count", 128'(fifo_count), 128'(1));
    @(negedge clk);
    check("sim_eng_en", 128'(ub_en), 128'(1));
    check("sim_eng_we", 128'(ub_we), 128'(1));
    check("sim_eng_addr", 128'(ub_addr), 128'(16'h0300));
    @(negedge clk);
    check("sim_host_we", 128'(ub_we), 128'(0));
    check("sim_host_addr", 128'(ub_addr), 128'(16'h0030));
    check("sim_ack_early", 128'(host_ack), 128'(0));
    @(negedge clk);
    check("sim_ack", 128'(host_ack), 128'(1));
    check("sim_rdata", 128'(host_rdata), 128'(64'h5A5A_0000_0000_0030));
    host_req = 1'b0;
    @(negedge clk);
    check("hold_ub_en", 128'(ub_en), 128'(0));
    check("hold_ub_addr", 128'(ub_addr), 128'(16'h0030));
    check("hold_eng_idle", 128'(eng_idle), 128'(1));

    // Reset mid-operation: two host grants raise the FIFO to 3, host then in ISSUE
    for (int k = 0; k < 12; k++) begin
      if (k == 11) begin
        check("mid_count", 128'(fifo_count), 128'(3));
        check("mid_issue_en", 128'(ub_en), 128'(1));
        check("mid_issue_addr", 128'(ub_addr), 128'(16'h0040));
        rst = 1'b1; eng_valid = 1'b0; host_req = 1'b0;
      end else begin
        if (eng_ready !== 1'b1) check($sformatf("mid_ready_t%0d", k), 128'(eng_ready), 128'(1));
        eng_valid = 1'b1;
        eng_addr  = 16'h0400 + 16'(k);
        eng_wdata = 64'h4444_0000_0000_0000 + 64'(k);
        host_req  = (k >= 1);
        host_we   = 1'b0;
        host_addr = 16'h0040;
        host_wdata = '0;
      end
      @(negedge clk);
    end
    check("mid_rst_count", 128'(fifo_count), 128'(0));
    check("mid_rst_ack", 128'(host_ack), 128'(0));
    check("mid_rst_ub_en", 128'(ub_en), 128'(0));
    check("mid_rst_ready", 128'(eng_ready), 128'(1));
    rst = 1'b0;
    log_q.delete();
    repeat (6) @(negedge clk);
    check("post_rst_ack", 128'(host_ack), 128'(0));
    check("post_rst_idle", 128'(eng_idle), 128'(1));
    compare_log("post_rst_writes");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
